spi_frame_alu: RTL
==================

// Module: spi_frame_alu
// PURPOSE
//  Clocked stage downstream of the SPI slave. Synchronises the slave's chip-select (ss) into clk.
//  At each end of frame (ss rising), captures the slave's 10-bit decoded frame and executes the
//  2-bit operator on two 4-bit operands. Presents the 8-bit result with a valid/ready handshake
//  to the display/LED stage.
// PARAMETERS
//  SETTLE_CYC  2  clk cycles waited after synchronised ss rise before frame_bits is sampled (>=1)
//  SYNC_STG    2  flip-flop stages in the ss synchroniser (>=2)
// PORTS
//  clk         in   1   system clock
//  rst_n       in   1   asynchronous active-low reset
//  ss          in   1   raw SPI chip-select, active low, async to clk
//  frame_bits  in   10  slave frame: [1:0] opcode, [5:2] operand B, [9:6] operand A
//  res_ready   in   1   consumer accepts result when high with res_valid
//  res_valid   out  1   result[7:0] and flags are valid
//  result      out  8   operation result, zero-extended
//  carry       out  1   ADD carry-out / SUB borrow; 0 for the other ops
//  err         out  1   divide by zero (SPI_ALU_DIV_EN only); otherwise 0
//  overrun     out  1   sticky: a frame ended while an unaccepted result was held
//  busy        out  1   FSM not in IDLE/ARMED
// BEHAVIOUR
//  Reset: every output 0; FSM -> WAIT_HI; synchroniser flops reset to 1 (ss idle).
//  ss passes SYNC_STG flops; edges are detected on the last two stages only.
//  FSM:
//   WAIT_HI  sync ss==1 -> ARMED. Discards a frame in flight at reset release.
//   ARMED    ss fall -> ACTIVE
//   ACTIVE   ss rise -> SETTLE; settle counter loaded with SETTLE_CYC-1
//   SETTLE   count to 0, then sample frame_bits into op/a/b regs -> EXEC
//   EXEC     1 cycle for ADD/SUB/MUL/AND; divide per CONFIGURATION -> HOLD;
//            outputs registered on exit
//   HOLD     res_valid=1; res_valid&&res_ready -> ARMED, res_valid=0 next cycle, overrun clears
//  Latency: ss rise at sync output -> res_valid = SETTLE_CYC+2 clk (1-cycle ops).
//  Arithmetic, unsigned 4-bit:
//   00 ADD  result = {3'b0, A+B}, carry = bit4
//   01 SUB  result = {4'b0, (A-B) mod 16}, carry = (A<B)
//   10 MUL  result = A*B (max 225)
//   11 AND  result = {4'b0, A&B}
//  Result, flags and res_valid stay stable in HOLD until accepted.
//  ss fall in HOLD: that frame is dropped (no capture), overrun<=1, FSM stays HOLD.
//  ss fall during SETTLE/EXEC: in-progress op completes; that new frame is dropped;
//   overrun<=1; ARMED re-entered only after HOLD handshake and sync ss==1.
//  res_ready high outside HOLD: ignored.
//  Async reset mid-frame or mid-divide: immediate clear; the next frame begins only after ss seen high.
// CONFIGURATION
//  Macro SPI_ALU_DIV_EN.
//   Defined:   opcode 11 = DIV. result = {quotient[3:0], remainder[3:0]}; 4-cycle restoring
//              divide in EXEC, so latency +3 clk. B==0 -> result=8'hFF, err=1, carry=0, 1 cycle.
//   Undefined: opcode 11 = AND; err tied 0; no divider logic.
// STRUCTURE
//  Package spi_alu_pkg:
//   opcode enum: OP_ADD=2'b00, OP_SUB, OP_MUL, OP_AND_DIV
//   FSM state enum
//   localparams OPW=4, OPCW=2, RESW=8, and frame-field bit positions
//  Sub-module alu_div4 (only under SPI_ALU_DIV_EN):
//   in  start, a[3:0], b[3:0]; out done, q[3:0], r[3:0]
//   iterative, one quotient bit per clk, same clk/rst_n
// TESTING
//  1 Reset with ss=0, then frame A=9,B=5,op=ADD, ss rise
//    -> first frame ignored; next frame gives result=14, carry=0, valid at SETTLE_CYC+2 clk.
//  2 A=15,B=15 for each op, res_ready=1
//    -> ADD 30/carry1, SUB 0/carry0, MUL 225, AND 15
//  3 A=3,B=7,op=SUB -> result=12, carry=1
//  4 res_ready held 0 while a second frame arrives
//    -> first result held stable, overrun=1; after accept overrun=0 and the second frame is not executed.
//  5 SPI_ALU_DIV_EN: A=13,B=4 -> result=8'h31 after 4 EXEC clk; B=0 -> 8'hFF, err=1.
//    Without macro, same frame -> AND = 4.
//  6 rst_n asserted in SETTLE and mid-divide
//    -> all outputs 0 same cycle; busy=0; correct op on the next clean frame.

Source files
------------

// File: rtl/spi_alu_pkg.sv
// Shared types and constants for the SPI frame ALU: frame field layout, opcodes,
// FSM states and the single-cycle operator evaluation.
package spi_alu_pkg;
  localparam int OPW   = 4;
  localparam int OPCW  = 2;
  localparam int RESW  = 8;
  localparam int FRW   = 10;
  localparam int OP_LSB = 0;
  localparam int B_LSB  = 2;
  localparam int A_LSB  = 6;

  typedef enum logic [1:0] {
    OP_ADD     = 2'b00,
    OP_SUB     = 2'b01,
    OP_MUL     = 2'b10,
    OP_AND_DIV = 2'b11
  } opcode_e;

  typedef enum logic [2:0] {
    ST_WAIT_HI,
    ST_ARMED,
    ST_ACTIVE,
    ST_SETTLE,
    ST_EXEC,
    ST_HOLD
  } state_e;

  typedef struct packed {
    logic [RESW-1:0] result;
    logic            carry;
    logic            err;
  } alu_res_t;

  // Opcode 11 evaluates as AND here; the divide build overrides it in the top.
  function automatic alu_res_t alu_1cyc(input opcode_e op, input logic [OPW-1:0] a,
                                        input logic [OPW-1:0] b);
    alu_res_t   r;
    logic [OPW:0] s;
    r = '0;
    s = {1'b0, a} + {1'b0, b};
    case (op)
      OP_ADD: begin
        r.result = {3'b0, s};
        r.carry  = s[OPW];
      end
      OP_SUB: begin
        r.result = {4'b0, a - b};
        r.carry  = (a < b);
      end
      OP_MUL:  r.result = {4'b0, a} * {4'b0, b};
      default: r.result = {4'b0, a & b};
    endcase
    return r;
  endfunction
endpackage

// File: rtl/alu_div4.sv
// 4-bit restoring divider, one quotient bit per clock. done/q/r present the
// final step combinationally in the fourth cycle after start.
module alu_div4
  import spi_alu_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  output logic           done,
  output logic [OPW-1:0] q,
  output logic [OPW-1:0] r
);
  logic [OPW-1:0] q_q, q_d, r_q, r_d, b_q, b_d, q_step, r_step;
  logic [2:0]     cnt_q, cnt_d;
  logic [OPW:0]   sh;

  always_comb begin
    sh     = {r_q, q_q[OPW-1]};
    q_step = {q_q[OPW-2:0], 1'b0};
    r_step = sh[OPW-1:0];
    if (sh >= {1'b0, b_q}) begin
      q_step[0] = 1'b1;
      r_step    = sh[OPW-1:0] - b_q;
    end
    q_d   = q_q;
    r_d   = r_q;
    b_d   = b_q;
    cnt_d = cnt_q;
    if (start) begin
      q_d   = a;
      r_d   = '0;
      b_d   = b;
      cnt_d = 3'd4;
    end else if (cnt_q != '0) begin
      q_d   = q_step;
      r_d   = r_step;
      cnt_d = cnt_q - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q   <= '0;
      r_q   <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      r_q   <= r_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == 3'd1);
  assign q    = q_step;
  assign r    = r_step;
endmodule

// File: rtl/spi_frame_alu.sv
// End-of-frame ALU stage behind the SPI slave, with valid/ready result port.
// SPI_ALU_DIV_EN turns opcode 11 into a 4-cycle divide instead of AND.
module spi_frame_alu
  import spi_alu_pkg::*;
#(
  parameter int SETTLE_CYC = 2,
  parameter int SYNC_STG   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ss,
  input  logic [FRW-1:0]  frame_bits,
  input  logic            res_ready,
  output logic            res_valid,
  output logic [RESW-1:0] result,
  output logic            carry,
  output logic            err,
  output logic            overrun,
  output logic            busy
);
  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  logic [SYNC_STG-1:0] sync_q, sync_d, fill_q, fill_d;
  logic                ss_s, ss_p, ss_rise, ss_fall, sync_ok;
  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  opcode_e             op_q, op_d;
  logic [OPW-1:0]      a_q, a_d, b_q, b_d;
  alu_res_t            res_q, res_d, exec_res;
  logic                valid_q, valid_d, ovr_q, ovr_d, exec_done;

  // fill_q keeps WAIT_HI from trusting the reset value of the synchroniser.
  assign sync_d  = {sync_q[SYNC_STG-2:0], ss};
  assign fill_d  = {fill_q[SYNC_STG-2:0], 1'b1};
  assign ss_s    = sync_q[SYNC_STG-2];
  assign ss_p    = sync_q[SYNC_STG-1];
  assign ss_rise = ss_s & ~ss_p;
  assign ss_fall = ~ss_s & ss_p;
  assign sync_ok = fill_q[SYNC_STG-1];

`ifdef SPI_ALU_DIV_EN
  logic           div_start, div_done;
  logic [OPW-1:0] div_q, div_r;
  assign div_start = (state_q == ST_SETTLE) && (cnt_q == '0);
  alu_div4 u_div (
    .clk  (clk),
    .rst_n(rst_n),
    .start(div_start),
    .a    (frame_bits[A_LSB +: OPW]),
    .b    (frame_bits[B_LSB +: OPW]),
    .done (div_done),
    .q    (div_q),
    .r    (div_r)
  );
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    valid_d   = valid_q;
    ovr_d     = ovr_q;
    exec_done = 1'b0;
    exec_res  = '0;
    case (state_q)
      ST_WAIT_HI: if (sync_ok && ss_s) state_d = ST_ARMED;
      ST_ARMED:   if (ss_fall) state_d = ST_ACTIVE;
      ST_ACTIVE: begin
        if (ss_rise) begin
          state_d = ST_SETTLE;
          cnt_d   = CW'(SETTLE_CYC - 1);
        end
      end
      ST_SETTLE: begin
        if (ss_fall) ovr_d = 1'b1;
        if (cnt_q == '0) begin
          op_d    = opcode_e'(frame_bits[OP_LSB +: OPCW]);
          a_d     = frame_bits[A_LSB +: OPW];
          b_d     = frame_bits[B_LSB +: OPW];
          state_d = ST_EXEC;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_EXEC: begin
        if (ss_fall) ovr_d = 1'b1;
        exec_done = 1'b1;
        exec_res  = alu_1cyc(op_q, a_q, b_q);
`ifdef SPI_ALU_DIV_EN
        if (op_q == OP_AND_DIV) begin
          if (b_q == '0) begin
            exec_res = '{result: 8'hFF, carry: 1'b0, err: 1'b1};
          end else begin
            exec_done = div_done;
            exec_res  = '{result: {div_q, div_r}, carry: 1'b0, err: 1'b0};
          end
        end
`endif
        if (exec_done) begin
          res_d   = exec_res;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (ss_fall) ovr_d = 1'b1;
        if (valid_q && res_ready) begin
          valid_d = 1'b0;
          ovr_d   = ss_fall;
          // A frame still in flight at accept is dropped; wait for ss high first.
          state_d = ss_s ? ST_ARMED : ST_WAIT_HI;
        end
      end
      default: state_d = ST_WAIT_HI;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '1;
      fill_q  <= '0;
      state_q <= ST_WAIT_HI;
      cnt_q   <= '0;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      fill_q  <= fill_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign res_valid = valid_q;
  assign result    = res_q.result;
  assign carry     = res_q.carry;
  assign err       = res_q.err;
  assign overrun   = ovr_q;
  assign busy      = !(state_q inside {ST_WAIT_HI, ST_ARMED});
endmodule
